// File: rtl/half_life_ctrl_if.sv
// Bus bundle for half_life_ctrl.
// Carries the run request (start/abort/period/init_amt/thresh) and the
// external counter link (cnt_val in; cnt_clr/up/down/load/cnt_in out).
// It also carries the status outputs (amount, halvings, busy, done, err).
// slave  : the controller side.
// master : the requester / counter side.
interface half_life_ctrl_if #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 8,
    parameter int unsigned H = 4
);
    logic         start;
    logic         abort;
    logic [N-1:0] period;
    logic [M-1:0] init_amt;
    logic [M-1:0] thresh;
    logic [N-1:0] cnt_val;
    logic         cnt_clr;
    logic         cnt_up;
    logic         cnt_down;
    logic         cnt_load;
    logic [N-1:0] cnt_in;
    logic [M-1:0] amount;
    logic [H-1:0] halvings;
    logic         busy;
    logic         done;
    logic         err;

    modport slave (
        input  start, abort, period, init_amt, thresh, cnt_val,
        output cnt_clr, cnt_up, cnt_down, cnt_load, cnt_in,
        output amount, halvings, busy, done, err
    );

    modport master (
        output start, abort, period, init_amt, thresh, cnt_val,
        input  cnt_clr, cnt_up, cnt_down, cnt_load, cnt_in,
        input  amount, halvings, busy, done, err
    );
endinterface

// File: rtl/half_life_ctrl.sv
// Half-life decay controller.
// It drives an external up/down/load counter so that each half-life lasts
// period+3 cycles: LOAD, then COUNT down to zero, then HALVE.
// On every HALVE the quantity is halved.
// The run stops when the quantity reaches the threshold, when the halvings
// count saturates, or when abort is raised.
// Ports:
//   i_clk  : clock, rising edge.
//   i_rst  : synchronous active-high reset.
//   io_bus : half_life_ctrl_if.slave, which carries the request inputs,
//            the counter link and the status outputs.
module half_life_ctrl #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 8,
    parameter int unsigned H = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    half_life_ctrl_if.slave        io_bus
);
    typedef enum logic [2:0] {StIdle, StLoad, StCount, StHalve, StDone} state_e;

    localparam logic [H-1:0] HalvMax = '1;

    state_e       r_state;
    state_e       w_state_d;
    logic [M-1:0] r_amount;
    logic [H-1:0] r_halvings;
    logic [M-1:0] r_thresh;
    logic         r_err;

    logic         w_start_ok;
    logic         w_start_bad;
    logic [M-1:0] w_amt_half;
    logic [H-1:0] w_halv_inc;
    logic         w_clr;
    logic         w_down;
    logic         w_load;
    logic [N-1:0] w_cnt_in;

    assign w_start_ok  = (r_state == StIdle) && io_bus.start &&
                         (io_bus.period != '0) && (io_bus.init_amt != '0);
    assign w_start_bad = (r_state == StIdle) && io_bus.start && !w_start_ok;
    assign w_amt_half  = r_amount >> 1;
    assign w_halv_inc  = r_halvings + {{(H-1){1'b0}}, 1'b1};

    always_comb begin
        w_state_d = r_state;
        w_clr     = 1'b0;
        w_down    = 1'b0;
        w_load    = 1'b0;
        w_cnt_in  = '0;
        unique case (r_state)
            StIdle: begin
                if (w_start_ok) w_state_d = StLoad;
            end
            StLoad: begin
                if (io_bus.abort) begin
                    w_clr     = 1'b1;
                    w_state_d = StIdle;
                end else begin
                    w_load    = 1'b1;
                    w_cnt_in  = io_bus.period;
                    w_state_d = StCount;
                end
            end
            StCount: begin
                if (io_bus.abort) begin
                    w_clr     = 1'b1;
                    w_state_d = StIdle;
                end else if (io_bus.cnt_val != '0) begin
                    w_down = 1'b1;
                end else begin
                    w_state_d = StHalve;
                end
            end
            StHalve: begin
                if (io_bus.abort) begin
                    w_clr     = 1'b1;
                    w_state_d = StIdle;
                end else if ((w_amt_half <= r_thresh) || (w_halv_inc == HalvMax)) begin
                    // Decide on the post-halving values so saturation never wraps.
                    w_state_d = StDone;
                end else begin
                    w_state_d = StLoad;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
        // Reset clears the counter in the same cycle and masks any other control.
        if (i_rst) begin
            w_clr    = 1'b1;
            w_down   = 1'b0;
            w_load   = 1'b0;
            w_cnt_in = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_amount   <= '0;
            r_halvings <= '0;
            r_thresh   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_err   <= w_start_bad;
            if (w_start_ok) begin
                r_amount   <= io_bus.init_amt;
                r_halvings <= '0;
                r_thresh   <= io_bus.thresh;
            end else if ((r_state == StHalve) && !io_bus.abort) begin
                r_amount   <= w_amt_half;
                r_halvings <= w_halv_inc;
            end
        end
    end

    assign io_bus.cnt_clr  = w_clr;
    assign io_bus.cnt_up   = 1'b0;
    assign io_bus.cnt_down = w_down;
    assign io_bus.cnt_load = w_load;
    assign io_bus.cnt_in   = w_cnt_in;
    assign io_bus.amount   = r_amount;
    assign io_bus.halvings = r_halvings;
    assign io_bus.busy     = (r_state == StLoad) || (r_state == StCount) ||
                             (r_state == StHalve);
    assign io_bus.done     = (r_state == StDone);
    assign io_bus.err      = r_err;
endmodule

// File: doc/half_life_ctrl.md
HALF_LIFE_CTRL -- requirements
Module: half_life_ctrl

Interface
REQ-001 Parameters: N, default 4, period/counter width; M, default 8, amount width; H, default 4, half-life count width.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  single-cycle request to begin a decay run; sampled only in IDLE.
REQ-005 abort  input  1  terminate the active run.
REQ-006 period  input  N  half-life duration in counter ticks; sampled with start and in every LOAD.
REQ-007 init_amt  input  M  starting quantity; sampled with start.
REQ-008 thresh  input  M  stop threshold; sampled with start.
REQ-009 cnt_val  input  N  registered output of the external up/down/load counter.
REQ-010 cnt_clr, cnt_up, cnt_down, cnt_load  output  1 each  counter controls; at most one high per cycle.
REQ-011 cnt_in  output  N  counter load value.
REQ-012 amount  output  M  current quantity (registered).
REQ-013 halvings  output  H  completed half-lives (registered).
REQ-014 busy  output  1  high in LOAD, COUNT, HALVE.
REQ-015 done  output  1  one-cycle pulse on normal completion.
REQ-016 err  output  1  one-cycle pulse on a rejected start.

Function
REQ-017 FSM states: IDLE, LOAD, COUNT, HALVE, DONE.
REQ-018 IDLE: start=1 with period!=0 and init_amt!=0 -> latch amount=init_amt, halvings=0, threshold register=thresh; go LOAD.
REQ-019 IDLE: start=1 with period==0 or init_amt==0 -> err=1 next cycle, stay IDLE, amount/halvings unchanged.
REQ-020 LOAD: cnt_load=1, cnt_in=period for exactly one cycle; go COUNT.
REQ-021 COUNT: cnt_val!=0 -> cnt_down=1, stay COUNT; cnt_val==0 -> cnt_down=0, go HALVE.
REQ-022 COUNT thus lasts period+1 cycles; one half-life = period+3 cycles (LOAD + COUNT + HALVE).
REQ-023 HALVE: amount <= amount>>1 (logical, floor); halvings <= halvings+1.
REQ-024 HALVE exit: new amount <= threshold register, or new halvings == 2^H-1 -> DONE; else -> LOAD (period resampled).
REQ-025 DONE: done=1 for one cycle; go IDLE; amount and halvings hold final values until next accepted start.
REQ-026 cnt_up is never asserted; cnt_in=0 whenever cnt_load=0.
REQ-027 abort=1 in LOAD, COUNT or HALVE: next state IDLE, cnt_clr=1 that cycle, no HALVE update, no done; amount/halvings hold.
REQ-028 abort has priority over all same-cycle transitions; abort in IDLE or DONE ignored (DONE still pulses done).
REQ-029 start while busy or in DONE ignored.
REQ-030 halvings never wraps; saturation forces DONE per REQ-024.

Reset
REQ-031 rst=1 at a clock edge: state IDLE; amount=0, halvings=0, busy=0, done=0, err=0, cnt_up=cnt_down=cnt_load=0, cnt_in=0.
REQ-032 cnt_clr=1 while rst=1 so the counter clears in the same cycle.
REQ-033 rst overrides abort, start and any in-progress run, in any state.

Verification (N=4, M=8, H=4 unless stated; cycle 0 = start edge)
REQ-034 period=3, init_amt=100, thresh=10 -> LOAD at cycle 1, HALVE at cycles 6/12/18/24, amount 50/25/12/6; done at cycle 25; halvings=4, amount=6.
REQ-035 H=3, period=1, init_amt=255, thresh=0 -> 7 halvings, amount=1, done via saturation, halvings=7.
REQ-036 period=0 or init_amt=0 with start -> err pulse one cycle, busy stays 0, no counter control asserted.
REQ-037 period=5, init_amt=64, thresh=0; abort at cycle 4 -> cnt_clr high for one cycle, IDLE next, amount=64, halvings=0, no done.
REQ-038 rst asserted mid-COUNT -> next cycle all outputs at reset values; then start with period=2, init_amt=8, thresh=1 -> amount 4/2/1, done at cycle 16.
REQ-039 start pulsed while busy -> no effect on amount, halvings or FSM timing.
